// File: rtl/pipeline_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl_pkg
// Shared types and constants for the five-stage pipeline stall/flush
// controller and its hazard-detection helper.
//
//   ctrl_state_t : controller state (RUN, MEM_WAIT, HALT)
//   REG_W        : width of an architectural register index
// ---------------------------------------------------------------------------
package pipeline_ctrl_pkg;

  localparam int REG_W = 5;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } ctrl_state_t;

endpackage

// File: rtl/pipeline_ctrl_hazard.sv
// ---------------------------------------------------------------------------
// hazard_detect
// Combinational load-use hazard compare. Flags when the load currently in EX
// writes a register that the instruction in ID is about to read.
//
// Ports:
//   i_EX_mem_read : instruction in EX is a load
//   i_EX_rt       : destination register of the load in EX
//   i_ID_rs       : source register 1 of the instruction in ID
//   i_ID_rt       : source register 2 of the instruction in ID
//   o_load_use    : load-use hazard present this cycle
// ---------------------------------------------------------------------------
module hazard_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic             i_EX_mem_read,
  input  logic [REG_W-1:0] i_EX_rt,
  input  logic [REG_W-1:0] i_ID_rs,
  input  logic [REG_W-1:0] i_ID_rt,
  output logic             o_load_use
);

  logic w_dest_valid;
  logic w_src_match;

  // Register 0 is hard-wired zero, so a load into it never creates a hazard.
  assign w_dest_valid = (i_EX_rt != '0);
  assign w_src_match  = (i_EX_rt == i_ID_rs) || (i_EX_rt == i_ID_rt);
  assign o_load_use   = i_EX_mem_read && w_dest_valid && w_src_match;

endmodule

// File: rtl/pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl
// Central stall/flush controller for the five-stage pipeline. Drives the
// load enables and flush/bubble controls of the pipeline registers, resolves
// load-use and taken-branch hazards, sequences the variable-latency data
// memory handshake and halts the pipeline if memory never answers.
//
// Parameters:
//   TIMEOUT : consecutive not-ready request cycles before HALT (>= 2)
//   CNT_W   : width of stall_count
//
// Ports:
//   clk, rst           : clock, asynchronous active-low reset
//   ID_rs, ID_rt       : source registers of the instruction in ID
//   EX_mem_read, EX_rt : load in EX and its destination register
//   EX_branch_taken    : branch in EX resolved taken
//   MEM_access         : instruction in MEM is a load or store
//   dmem_ready         : data memory completes the access this cycle
//   dmem_req           : data-memory request
//   pc_en .. MEM_WB_en : pipeline register load enables
//   IF_ID_flush, ID_EX_flush, MEM_WB_bubble : zero control fields on capture
//   mem_timeout        : sticky, set when HALT is entered
//   stall_count        : saturating count of stalled (pc_en = 0) cycles
// ---------------------------------------------------------------------------
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] ID_rs,
  input  logic [REG_W-1:0] ID_rt,
  input  logic             EX_mem_read,
  input  logic [REG_W-1:0] EX_rt,
  input  logic             EX_branch_taken,
  input  logic             MEM_access,
  input  logic             dmem_ready,
  output logic             dmem_req,
  output logic             pc_en,
  output logic             IF_ID_en,
  output logic             ID_EX_en,
  output logic             EX_MEM_en,
  output logic             MEM_WB_en,
  output logic             IF_ID_flush,
  output logic             ID_EX_flush,
  output logic             MEM_WB_bubble,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_count
);

  // Wide enough to hold TIMEOUT itself so the terminal compare cannot wrap.
  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  ctrl_state_t       r_state;
  ctrl_state_t       w_next_state;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [WAIT_W-1:0] w_next_wait_cnt;
  logic [CNT_W-1:0]  r_stall_count;
  logic              r_mem_timeout;
  logic              w_load_use;
  logic              w_mem_stall;
  logic              w_wait_expired;

  hazard_detect u_hazard_detect (
    .i_EX_mem_read (EX_mem_read),
    .i_EX_rt       (EX_rt),
    .i_ID_rs       (ID_rs),
    .i_ID_rt       (ID_rt),
    .o_load_use    (w_load_use)
  );

  // A memory stall exists whenever an access is outstanding and memory has
  // not answered, whether the request is just starting or already waiting.
  assign w_mem_stall = ((r_state == RUN) && MEM_access && !dmem_ready) ||
                       ((r_state == MEM_WAIT) && !dmem_ready);

  // r_wait_cnt lags the request-cycle number by one, so this fires in the
  // TIMEOUT-th consecutive not-ready cycle.
  assign w_wait_expired = ((r_wait_cnt + WAIT_W'(1)) == WAIT_W'(TIMEOUT));

  // Next-state and wait-counter decode.
  always_comb begin
    w_next_state    = r_state;
    w_next_wait_cnt = r_wait_cnt;
    case (r_state)
      RUN: begin
        if (w_mem_stall) begin
          w_next_state    = MEM_WAIT;
          w_next_wait_cnt = WAIT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (dmem_ready) begin
          w_next_state    = RUN;
          w_next_wait_cnt = '0;
        end else begin
          w_next_wait_cnt = r_wait_cnt + WAIT_W'(1);
          if (w_wait_expired) begin
            w_next_state = HALT;
          end
        end
      end
      HALT: begin
        w_next_state = HALT;
      end
      default: begin
        w_next_state    = RUN;
        w_next_wait_cnt = '0;
      end
    endcase
  end

  // Mealy output decode in priority order: HALT, memory wait, branch,
  // load-use. A completing access falls through to the hazard checks.
  always_comb begin
    dmem_req      = MEM_access;
    pc_en         = 1'b1;
    IF_ID_en      = 1'b1;
    ID_EX_en      = 1'b1;
    EX_MEM_en     = 1'b1;
    MEM_WB_en     = 1'b1;
    IF_ID_flush   = 1'b0;
    ID_EX_flush   = 1'b0;
    MEM_WB_bubble = 1'b0;

    if (r_state == MEM_WAIT) begin
      dmem_req = 1'b1;
    end

    if (r_state == HALT) begin
      dmem_req  = 1'b0;
      pc_en     = 1'b0;
      IF_ID_en  = 1'b0;
      ID_EX_en  = 1'b0;
      EX_MEM_en = 1'b0;
      MEM_WB_en = 1'b0;
    end else if (w_mem_stall) begin
      pc_en         = 1'b0;
      IF_ID_en      = 1'b0;
      ID_EX_en      = 1'b0;
      EX_MEM_en     = 1'b0;
      MEM_WB_en     = 1'b0;
      MEM_WB_bubble = 1'b1;
    end else if (EX_branch_taken) begin
      IF_ID_flush = 1'b1;
      ID_EX_flush = 1'b1;
    end else if (w_load_use) begin
      // Freeze fetch/decode and inject a bubble into EX; older stages drain.
      pc_en       = 1'b0;
      IF_ID_en    = 1'b0;
      ID_EX_flush = 1'b1;
    end
  end

  // State and wait counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= RUN;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_next_state;
      r_wait_cnt <= w_next_wait_cnt;
    end
  end

  // Sticky timeout flag, raised on the edge that enters HALT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mem_timeout <= 1'b0;
    end else if ((r_state != HALT) && (w_next_state == HALT)) begin
      r_mem_timeout <= 1'b1;
    end
  end

  // Stall counter: cycles without PC advance, excluding HALT, saturating.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_count <= '0;
    end else if (!pc_en && (r_state != HALT) && (r_stall_count != '1)) begin
      r_stall_count <= r_stall_count + CNT_W'(1);
    end
  end

  assign mem_timeout = r_mem_timeout;
  assign stall_count = r_stall_count;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_ctrl
// Directed self-checking bench for pipeline_ctrl. A second instance with a
// 4-bit stall counter shares all inputs to exercise saturation.
// ---------------------------------------------------------------------------
module tb_pipeline_ctrl;

  logic        clk;
  logic        rst;
  logic [4:0]  ID_rs;
  logic [4:0]  ID_rt;
  logic        EX_mem_read;
  logic [4:0]  EX_rt;
  logic        EX_branch_taken;
  logic        MEM_access;
  logic        dmem_ready;

  logic        dmem_req, pc_en, IF_ID_en, ID_EX_en, EX_MEM_en, MEM_WB_en;
  logic        IF_ID_flush, ID_EX_flush, MEM_WB_bubble, mem_timeout;
  logic [31:0] stall_count;

  logic        sat_dmem_req, sat_pc_en, sat_IF_ID_en, sat_ID_EX_en;
  logic        sat_EX_MEM_en, sat_MEM_WB_en, sat_IF_ID_flush, sat_ID_EX_flush;
  logic        sat_MEM_WB_bubble, sat_mem_timeout;
  logic [3:0]  sat_stall_count;

  int          nVectors;
  int          nMiscompares;
  logic [31:0] expStall;

  wire [4:0] enables = {pc_en, IF_ID_en, ID_EX_en, EX_MEM_en, MEM_WB_en};
  wire [2:0] flushes = {IF_ID_flush, ID_EX_flush, MEM_WB_bubble};

  pipeline_ctrl #(.TIMEOUT(16), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .ID_rs(ID_rs), .ID_rt(ID_rt),
    .EX_mem_read(EX_mem_read), .EX_rt(EX_rt), .EX_branch_taken(EX_branch_taken),
    .MEM_access(MEM_access), .dmem_ready(dmem_ready), .dmem_req(dmem_req),
    .pc_en(pc_en), .IF_ID_en(IF_ID_en), .ID_EX_en(ID_EX_en),
    .EX_MEM_en(EX_MEM_en), .MEM_WB_en(MEM_WB_en), .IF_ID_flush(IF_ID_flush),
    .ID_EX_flush(ID_EX_flush), .MEM_WB_bubble(MEM_WB_bubble),
    .mem_timeout(mem_timeout), .stall_count(stall_count)
  );

  pipeline_ctrl #(.TIMEOUT(16), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .ID_rs(ID_rs), .ID_rt(ID_rt),
    .EX_mem_read(EX_mem_read), .EX_rt(EX_rt), .EX_branch_taken(EX_branch_taken),
    .MEM_access(MEM_access), .dmem_ready(dmem_ready), .dmem_req(sat_dmem_req),
    .pc_en(sat_pc_en), .IF_ID_en(sat_IF_ID_en), .ID_EX_en(sat_ID_EX_en),
    .EX_MEM_en(sat_EX_MEM_en), .MEM_WB_en(sat_MEM_WB_en),
    .IF_ID_flush(sat_IF_ID_flush), .ID_EX_flush(sat_ID_EX_flush),
    .MEM_WB_bubble(sat_MEM_WB_bubble), .mem_timeout(sat_mem_timeout),
    .stall_count(sat_stall_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task clearInputs;
    ID_rs = '0; ID_rt = '0; EX_mem_read = 1'b0; EX_rt = '0;
    EX_branch_taken = 1'b0; MEM_access = 1'b0; dmem_ready = 1'b0;
  endtask

  // Inputs change on the falling edge; checks follow 1 time unit later.
  task nextCycle;
    @(negedge clk);
  endtask

  task test_reset;
    rst = 1'b0;
    clearInputs();
    #3;
    nVectors++;
    if (enables !== 5'b11111) begin nMiscompares++; $display("[TB] FAIL reset_enables: got %b expected %b", enables, 5'b11111); end
    nVectors++;
    if (flushes !== 3'b000) begin nMiscompares++; $display("[TB] FAIL reset_flushes: got %b expected %b", flushes, 3'b000); end
    nVectors++;
    if (dmem_req !== 1'b0) begin nMiscompares++; $display("[TB] FAIL reset_dmem_req: got %b expected 0", dmem_req); end
    nVectors++;
    if (stall_count !== 32'd0) begin nMiscompares++; $display("[TB] FAIL reset_stall_count: got %0d expected 0", stall_count); end
    nVectors++;
    if (mem_timeout !== 1'b0) begin nMiscompares++; $display("[TB] FAIL reset_mem_timeout: got %b expected 0", mem_timeout); end
    @(negedge clk);
    rst = 1'b1;
    expStall = 0;
  endtask

  task test_load_use;
    nextCycle(); clearInputs();
    EX_mem_read = 1'b1; EX_rt = 5'd8; ID_rs = 5'd8;
    #1;
    nVectors++;
    if (enables !== 5'b00111) begin nMiscompares++; $display("[TB] FAIL loaduse_rs_enables: got %b expected %b", enables, 5'b00111); end
    nVectors++;
    if (flushes !== 3'b010) begin nMiscompares++; $display("[TB] FAIL loaduse_rs_flushes: got %b expected %b", flushes, 3'b010); end
    nVectors++;
    if (stall_count !== 32'd0) begin nMiscompares++; $display("[TB] FAIL loaduse_count_before: got %0d expected 0", stall_count); end
    nextCycle(); clearInputs();
    expStall = 1;
    #1;
    nVectors++;
    if (stall_count !== expStall) begin nMiscompares++; $display("[TB] FAIL loaduse_count_after: got %0d expected %0d", stall_count, expStall); end
    nVectors++;
    if (enables !== 5'b11111) begin nMiscompares++; $display("[TB] FAIL loaduse_idle_enables: got %b expected %b", enables, 5'b11111); end
    // Load into register 0 never stalls.
    EX_mem_read = 1'b1; EX_rt = 5'd0; ID_rs = 5'd0; ID_rt = 5'd0;
    #1;
    nVectors++;
    if (enables !== 5'b11111) begin nMiscompares++; $display("[TB] FAIL loaduse_r0_enables: got %b expected %b", enables, 5'b11111); end
    nVectors++;
    if (flushes !== 3'b000) begin nMiscompares++; $display("[TB] FAIL loaduse_r0_flushes: got %b expected %b", flushes, 3'b000); end
    // Match on the second source register.
    nextCycle(); clearInputs();
    EX_mem_read = 1'b1; EX_rt = 5'd5; ID_rt = 5'd5; ID_rs = 5'd3;
    #1;
    nVectors++;
    if (enables !== 5'b00111) begin nMiscompares++; $display("[TB] FAIL loaduse_rt_enables: got %b expected %b", enables, 5'b00111); end
    nVectors++;
    if (stall_count !== expStall) begin nMiscompares++; $display("[TB] FAIL loaduse_r0_nocount: got %0d expected %0d", stall_count, expStall); end
    // Same registers but not a load: no hazard.
    nextCycle(); clearInputs();
    EX_rt = 5'd5; ID_rt = 5'd5;
    expStall = 2;
    #1;
    nVectors++;
    if (enables !== 5'b11111) begin nMiscompares++; $display("[TB] FAIL loaduse_noload_enables: got %b expected %b", enables, 5'b11111); end
    nVectors++;
    if (stall_count !== expStall) begin nMiscompares++; $display("[TB] FAIL loaduse_rt_count: got %0d expected %0d", stall_count, expStall); end
  endtask

  task test_branch;
    nextCycle(); clearInputs();
    EX_branch_taken = 1'b1; EX_mem_read = 1'b1; EX_rt = 5'd8; ID_rs = 5'd8;
    #1;
    nVectors++;
    if (enables !== 5'b11111) begin nMiscompares++; $display("[TB] FAIL branch_enables: got %b expected %b", enables, 5'b11111); end
    nVectors++;
    if (flushes !== 3'b110) begin nMiscompares++; $display("[TB] FAIL branch_flushes: got %b expected %b", flushes, 3'b110); end
    nextCycle(); clearInputs();
    #1;
    nVectors++;
    if (stall_count !== expStall) begin nMiscompares++; $display("[TB] FAIL branch_count: got %0d expected %0d", stall_count, expStall); end
  endtask

  task test_mem_latency;
    for (int c = 1; c <= 3; c++) begin
      nextCycle(); clearInputs();
      MEM_access = 1'b1;
      // A taken branch during the wait must not override the stall.
      EX_branch_taken = (c == 2);
      #1;
      nVectors++;
      if (dmem_req !== 1'b1) begin nMiscompares++; $display("[TB] FAIL memlat_req_c%0d: got %b expected 1", c, dmem_req); end
      nVectors++;
      if (enables !== 5'b00000) begin nMiscompares++; $display("[TB] FAIL memlat_enables_c%0d: got %b expected %b", c, enables, 5'b00000); end
      nVectors++;
      if (flushes !== 3'b001) begin nMiscompares++; $display("[TB] FAIL memlat_flushes_c%0d: got %b expected %b", c, flushes, 3'b001); end
    end
    // Completion cycle with a load-use pattern: hazard logic applies.
    nextCycle(); clearInputs();
    MEM_access = 1'b1; dmem_ready = 1'b1;
    EX_mem_read = 1'b1; EX_rt = 5'd8; ID_rs = 5'd8;
    #1;
    nVectors++;
    if (dmem_req !== 1'b1) begin nMiscompares++; $display("[TB] FAIL memlat_req_done: got %b expected 1", dmem_req); end
    nVectors++;
    if (enables !== 5'b00111) begin nMiscompares++; $display("[TB] FAIL memlat_enables_done: got %b expected %b", enables, 5'b00111); end
    nVectors++;
    if (flushes !== 3'b010) begin nMiscompares++; $display("[TB] FAIL memlat_flushes_done: got %b expected %b", flushes, 3'b010); end
    nextCycle(); clearInputs();
    expStall = expStall + 4;
    #1;
    nVectors++;
    if (dmem_req !== 1'b0) begin nMiscompares++; $display("[TB] FAIL memlat_req_run: got %b expected 0", dmem_req); end
    nVectors++;
    if (enables !== 5'b11111) begin nMiscompares++; $display("[TB] FAIL memlat_enables_run: got %b expected %b", enables, 5'b11111); end
    nVectors++;
    if (stall_count !== expStall) begin nMiscompares++; $display("[TB] FAIL memlat_count: got %0d expected %0d", stall_count, expStall); end
    // Single-cycle access: no stall at all.
    nextCycle(); clearInputs();
    MEM_access = 1'b1; dmem_ready = 1'b1;
    #1;
    nVectors++;
    if (enables !== 5'b11111) begin nMiscompares++; $display("[TB] FAIL onecycle_enables: got %b expected %b", enables, 5'b11111); end
    nVectors++;
    if (dmem_req !== 1'b1) begin nMiscompares++; $display("[TB] FAIL onecycle_req: got %b expected 1", dmem_req); end
    nextCycle(); clearInputs();
    #1;
    nVectors++;
    if (stall_count !== expStall) begin nMiscompares++; $display("[TB] FAIL onecycle_count: got %0d expected %0d", stall_count, expStall); end
  endtask

  task test_watchdog_complete;
    for (int c = 1; c <= 15; c++) begin
      nextCycle(); clearInputs();
      MEM_access = 1'b1;
      #1;
      nVectors++;
      if (enables !== 5'b00000 || dmem_req !== 1'b1) begin nMiscompares++; $display("[TB] FAIL wdok_wait_c%0d: got en=%b req=%b expected en=00000 req=1", c, enables, dmem_req); end
    end
    nextCycle();
    dmem_ready = 1'b1;
    #1;
    nVectors++;
    if (enables !== 5'b11111 || dmem_req !== 1'b1) begin nMiscompares++; $display("[TB] FAIL wdok_done: got en=%b req=%b expected en=11111 req=1", enables, dmem_req); end
    nextCycle(); clearInputs();
    expStall = expStall + 15;
    #1;
    nVectors++;
    if (mem_timeout !== 1'b0) begin nMiscompares++; $display("[TB] FAIL wdok_timeout: got %b expected 0", mem_timeout); end
    nVectors++;
    if (enables !== 5'b11111) begin nMiscompares++; $display("[TB] FAIL wdok_run_enables: got %b expected %b", enables, 5'b11111); end
    nVectors++;
    if (stall_count !== expStall) begin nMiscompares++; $display("[TB] FAIL wdok_count: got %0d expected %0d", stall_count, expStall); end
  endtask

  task test_watchdog_halt;
    for (int c = 1; c <= 16; c++) begin
      nextCycle(); clearInputs();
      MEM_access = 1'b1;
      #1;
      nVectors++;
      if (enables !== 5'b00000 || mem_timeout !== 1'b0) begin nMiscompares++; $display("[TB] FAIL wdhalt_wait_c%0d: got en=%b to=%b expected en=00000 to=0", c, enables, mem_timeout); end
    end
    expStall = expStall + 16;
    for (int c = 1; c <= 4; c++) begin
      nextCycle();
      // Ready and hazards after the fact must not revive the pipeline.
      dmem_ready = (c > 1);
      EX_mem_read = 1'b1; EX_rt = 5'd8; ID_rs = 5'd8;
      #1;
      nVectors++;
      if (mem_timeout !== 1'b1) begin nMiscompares++; $display("[TB] FAIL wdhalt_timeout_c%0d: got %b expected 1", c, mem_timeout); end
      nVectors++;
      if (enables !== 5'b00000 || dmem_req !== 1'b0) begin nMiscompares++; $display("[TB] FAIL wdhalt_outputs_c%0d: got en=%b req=%b expected en=00000 req=0", c, enables, dmem_req); end
      nVectors++;
      if (stall_count !== expStall) begin nMiscompares++; $display("[TB] FAIL wdhalt_count_c%0d: got %0d expected %0d", c, stall_count, expStall); end
    end
    // Only reset leaves HALT.
    #2;
    rst = 1'b0;
    clearInputs();
    #1;
    nVectors++;
    if (mem_timeout !== 1'b0 || stall_count !== 32'd0 || enables !== 5'b11111) begin nMiscompares++; $display("[TB] FAIL wdhalt_reset: got to=%b cnt=%0d en=%b expected to=0 cnt=0 en=11111", mem_timeout, stall_count, enables); end
    nextCycle();
    rst = 1'b1;
    expStall = 0;
  endtask

  task test_async_reset;
    nextCycle(); clearInputs();
    MEM_access = 1'b1;
    nextCycle();
    #1;
    nVectors++;
    if (stall_count !== 32'd1 || dmem_req !== 1'b1) begin nMiscompares++; $display("[TB] FAIL areset_prewait: got cnt=%0d req=%b expected cnt=1 req=1", stall_count, dmem_req); end
    // Mid-cycle, no clock edge: reset must take effect immediately.
    #1;
    rst = 1'b0;
    MEM_access = 1'b0;
    #1;
    nVectors++;
    if (dmem_req !== 1'b0) begin nMiscompares++; $display("[TB] FAIL areset_req: got %b expected 0", dmem_req); end
    nVectors++;
    if (enables !== 5'b11111) begin nMiscompares++; $display("[TB] FAIL areset_enables: got %b expected %b", enables, 5'b11111); end
    nVectors++;
    if (stall_count !== 32'd0 || mem_timeout !== 1'b0) begin nMiscompares++; $display("[TB] FAIL areset_regs: got cnt=%0d to=%b expected cnt=0 to=0", stall_count, mem_timeout); end
    nextCycle(); clearInputs();
    rst = 1'b1;
  endtask

  task test_saturation;
    logic [3:0] expSat;
    for (int c = 1; c <= 20; c++) begin
      nextCycle(); clearInputs();
      EX_mem_read = 1'b1; EX_rt = 5'd8; ID_rs = 5'd8;
      expSat = (c - 1 > 15) ? 4'd15 : 4'(c - 1);
      #1;
      nVectors++;
      if (sat_stall_count !== expSat) begin nMiscompares++; $display("[TB] FAIL sat_count_c%0d: got %0d expected %0d", c, sat_stall_count, expSat); end
    end
    nextCycle(); clearInputs();
    #1;
    nVectors++;
    if (sat_stall_count !== 4'd15) begin nMiscompares++; $display("[TB] FAIL sat_final: got %0d expected 15", sat_stall_count); end
    nVectors++;
    if (stall_count !== 32'd20) begin nMiscompares++; $display("[TB] FAIL sat_wide_count: got %0d expected 20", stall_count); end
  endtask

  initial begin
    nVectors     = 0;
    nMiscompares = 0;
    expStall     = 0;
    test_reset();
    test_load_use();
    test_branch();
    test_mem_latency();
    test_watchdog_complete();
    test_watchdog_halt();
    test_async_reset();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
